// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the sum accumulator.
// Defaults match the 4-bit adder feeding it (5-bit sum).
package sum_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int SUM_W_DEF = 5;
    localparam int ACC_W_DEF = 12;
    localparam int COUNT_DEF = 8;

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Combinational unsigned saturating adder.
// The carry flag reports that the true sum did not fit and was clamped.
module sat_add #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W-1:0] raw;

    always_comb begin
        {carry, raw} = {1'b0, a} + {1'b0, b};
        sum = carry ? {W{1'b1}} : raw;
    end

endmodule

// File: rtl/sum_accumulator.sv
// Frame accumulator: adds COUNT adder sums into a saturating total and
// presents the total with a sticky overflow flag over a valid/ready port.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int COUNT = COUNT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(COUNT + 1);

    state_t           state;
    logic             run;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic             handshake;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_b;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;
    logic             last;

    assign out_valid = (state == HOLD);

    // run keeps in_ready low until the first edge after reset release
    always_comb begin
        in_ready = 1'b0;
        if (run && !clear) begin
            in_ready = (state == ACCUM) ? 1'b1 : out_ready;
        end
    end

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready && !clear;

    // An accept while holding starts a fresh frame, so the old total is dropped
    assign add_a    = (state == HOLD) ? '0 : acc;
    assign add_b    = ACC_W'(in_sum);
    assign cnt_base = (state == HOLD) ? '0 : cnt;
    assign cnt_next = cnt_base + CNT_W'(1);
    assign ovf_next = ((state == ACCUM) && ovf) || add_carry;
    assign last     = (cnt_next == CNT_W'(COUNT));

    sat_add #(
        .W(ACC_W)
    ) u_sat_add (
        .a    (add_a),
        .b    (add_b),
        .sum  (add_sum),
        .carry(add_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            run     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_acc <= '0;
            out_ovf <= 1'b0;
        end else begin
            run <= 1'b1;
            if (clear) begin
                state <= ACCUM;
                acc   <= '0;
                cnt   <= '0;
                ovf   <= 1'b0;
            end else if (accept) begin
                acc <= add_sum;
                cnt <= cnt_next;
                ovf <= ovf_next;
                if (last) begin
                    state   <= HOLD;
                    out_acc <= add_sum;
                    out_ovf <= ovf_next;
                end else begin
                    state <= ACCUM;
                end
            end else if (handshake) begin
                state <= ACCUM;
                acc   <= '0;
                cnt   <= '0;
                ovf   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default instance plus a small
// ACC_W=6/COUNT=4 instance for the saturation cases.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_sum;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_acc;
    logic        out_ovf;

    logic        clear_o;
    logic        in_valid_o;
    logic        in_ready_o;
    logic [4:0]  in_sum_o;
    logic        out_valid_o;
    logic        out_ready_o;
    logic [5:0]  out_acc_o;
    logic        out_ovf_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_accumulator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sum   (in_sum),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_ovf  (out_ovf)
    );

    sum_accumulator #(
        .SUM_W(5),
        .ACC_W(6),
        .COUNT(4)
    ) dut_o (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear_o),
        .in_valid (in_valid_o),
        .in_ready (in_ready_o),
        .in_sum   (in_sum_o),
        .out_valid(out_valid_o),
        .out_ready(out_ready_o),
        .out_acc  (out_acc_o),
        .out_ovf  (out_ovf_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] v);
        in_valid = 1'b1;
        in_sum   = v;
        tick();
    endtask

    task automatic send_o(input logic [4:0] v);
        in_valid_o = 1'b1;
        in_sum_o   = v;
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        clear       = 1'b0;
        in_valid    = 1'b0;
        in_sum      = '0;
        out_ready   = 1'b1;
        clear_o     = 1'b0;
        in_valid_o  = 1'b0;
        in_sum_o    = '0;
        out_ready_o = 1'b1;

        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_acc", out_acc, 0);
        chk("rst_out_ovf", out_ovf, 0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", in_ready, 0);
        tick();
        chk("rel_in_ready", in_ready, 1);

        // Basic frame
        send(5); send(15); send(30); send(5); send(15); send(30); send(5);
        chk("basic_valid_after7", out_valid, 0);
        send(15);
        chk("basic_valid", out_valid, 1);
        chk("basic_acc", out_acc, 120);
        chk("basic_ovf", out_ovf, 0);
        in_valid = 1'b0;
        tick();
        chk("basic_drained", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(30);
        chk("bp_valid", out_valid, 1);
        chk("bp_acc", out_acc, 240);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_sum   = 30;
            #1;
            chk("bp_in_ready", in_ready, 0);
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_acc", out_acc, 240);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_handshake", out_valid, 0);
        tick();
        chk("bp_single", out_valid, 0);

        // Back-to-back frames with in_valid held high
        for (int i = 0; i < 8; i++) send(1);
        chk("b2b_first_valid", out_valid, 1);
        chk("b2b_first_acc", out_acc, 8);
        for (int i = 0; i < 7; i++) send(1);
        chk("b2b_second_not_yet", out_valid, 0);
        send(1);
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second_acc", out_acc, 8);
        in_valid = 1'b0;
        tick();
        chk("b2b_drained", out_valid, 0);

        // Clear mid-frame
        send(7); send(7); send(7);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_sum   = 7;
        #1;
        chk("clr_in_ready", in_ready, 0);
        tick();
        clear = 1'b0;
        for (int i = 0; i < 7; i++) send(1);
        chk("clr_valid_after7", out_valid, 0);
        send(1);
        chk("clr_valid", out_valid, 1);
        chk("clr_acc", out_acc, 8);

        // Clear while holding
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_hold_valid", out_valid, 0);
        out_ready = 1'b1;

        // Async reset mid-frame
        send(2); send(2); send(2); send(2);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_acc", out_acc, 0);
        chk("arst_out_ovf", out_ovf, 0);
        chk("arst_in_ready", in_ready, 0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) send(2);
        chk("arst_frame_valid", out_valid, 1);
        chk("arst_frame_acc", out_acc, 16);
        in_valid = 1'b0;
        tick();

        // Saturation on the narrow instance
        send_o(30); send_o(30); send_o(30);
        chk("ovf_valid_after3", out_valid_o, 0);
        send_o(30);
        chk("ovf_valid", out_valid_o, 1);
        chk("ovf_acc", out_acc_o, 63);
        chk("ovf_flag", out_ovf_o, 1);
        send_o(1); send_o(1); send_o(1);
        chk("ovf_next_not_yet", out_valid_o, 0);
        send_o(1);
        chk("ovf_next_valid", out_valid_o, 1);
        chk("ovf_next_acc", out_acc_o, 4);
        chk("ovf_next_flag", out_ovf_o, 0);
        in_valid_o = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
